// File: rtl/control_unit.sv
// Four-cycle FETCH/DECODE/EXEC/WB sequencer driving a registered accumulator mux and ALU select.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap opcodes 4'h4-4'hE into HALT with a sticky illegal flag.
module control_unit #(
  parameter int PC_WIDTH = 4,
  parameter int START_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          instr,
  input  logic                acc_zero,
  output logic [PC_WIDTH-1:0] pc,
  output logic [1:0]          mux_sel,
  output logic                mux_wr_en,
  output logic [1:0]          alu_op,
  output logic                busy,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_e;

  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ALU  = 4'h2;
  localparam logic [3:0] OP_JZ   = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [PC_WIDTH-1:0] PC_RESET = PC_WIDTH'(START_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic                illegal_q, illegal_d;
  logic [1:0]          mux_sel_q, mux_sel_d;
  logic [1:0]          alu_op_q, alu_op_d;
  logic                mux_wr_en_q, mux_wr_en_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;

  logic [3:0]          opcode;
  logic [PC_WIDTH-1:0] jump_tgt;

  assign opcode   = ir_q[7:4];
  assign jump_tgt = PC_WIDTH'(ir_q[3:0]);

  // Outputs are computed one cycle ahead so every output is a flop that reset clears directly.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    illegal_d   = illegal_q;
    mux_sel_d   = 2'b00;
    alu_op_d    = 2'b00;
    mux_wr_en_d = 1'b0;
    busy_d      = 1'b0;
    halted_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          busy_d  = 1'b1;
        end
      end

      FETCH: begin
        ir_d    = instr;
        state_d = DECODE;
        busy_d  = 1'b1;
        if (instr[7:4] == OP_LOAD) begin
          mux_sel_d = instr[1:0];
        end else if (instr[7:4] == OP_ALU) begin
          mux_sel_d = 2'b11;
          alu_op_d  = instr[1:0];
        end
      end

      DECODE: begin
        if (opcode == OP_HALT) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        else if (opcode inside {[4'h4:4'hE]}) begin
          state_d   = HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end
`endif
        else begin
          state_d     = EXEC;
          busy_d      = 1'b1;
          mux_sel_d   = mux_sel_q;
          alu_op_d    = alu_op_q;
          mux_wr_en_d = (opcode == OP_LOAD) || (opcode == OP_ALU);
        end
      end

      EXEC: begin
        state_d = WB;
        busy_d  = 1'b1;
      end

      WB: begin
        state_d = FETCH;
        busy_d  = 1'b1;
        if ((opcode == OP_JZ) && acc_zero) begin
          pc_d = jump_tgt;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end

      HALT: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= PC_RESET;
      ir_q        <= 8'h00;
      illegal_q   <= 1'b0;
      mux_sel_q   <= 2'b00;
      alu_op_q    <= 2'b00;
      mux_wr_en_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      illegal_q   <= illegal_d;
      mux_sel_q   <= mux_sel_d;
      alu_op_q    <= alu_op_d;
      mux_wr_en_q <= mux_wr_en_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign pc        = pc_q;
  assign mux_sel   = mux_sel_q;
  assign alu_op    = alu_op_q;
  assign mux_wr_en = mux_wr_en_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 4, program-counter width in bits.
REQ-002 SHALL have parameter START_PC, default 0, PC value loaded at reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin execution; sampled only in IDLE.
REQ-006 SHALL have port instr  input  8  instruction word from program memory at address pc; opcode = instr[7:4], field = instr[3:0].
REQ-007 SHALL have port acc_zero  input  1  high when accumulator equals zero.
REQ-008 SHALL have port pc  output  PC_WIDTH  program-memory address.
REQ-009 SHALL have port mux_sel  output  2  operand select for the registered 4:1 accumulator mux.
REQ-010 SHALL have port mux_wr_en  output  1  write enable for that mux's register.
REQ-011 SHALL have port alu_op  output  2  ALU operation select.
REQ-012 SHALL have port busy  output  1  high in FETCH, DECODE, EXEC and WB.
REQ-013 SHALL have port halted  output  1  high in HALT.
REQ-014 SHALL have port illegal  output  1  sticky undefined-opcode flag (see Configuration).

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB, HALT; one instruction takes exactly 4 cycles (FETCH, DECODE, EXEC, WB).
REQ-016 IDLE -> FETCH when start=1 at a clock edge; otherwise remain in IDLE; start ignored in all other states.
REQ-017 FETCH: internal instruction register SHALL capture instr at the FETCH->DECODE edge; FETCH -> DECODE unconditionally.
REQ-018 DECODE -> EXEC, except opcode 4'hF (HALT) -> HALT.
REQ-019 Opcode 4'h0 NOP: no write; EXEC -> WB.
REQ-020 Opcode 4'h1 LOAD: mux_sel = field[1:0] in DECODE and EXEC; mux_wr_en = 1 for the EXEC cycle only.
REQ-021 Opcode 4'h2 ALU: alu_op = field[1:0] and mux_sel = 2'b11 in DECODE and EXEC; mux_wr_en = 1 for the EXEC cycle only.
REQ-022 Opcode 4'h3 JZ: in WB, pc <= field zero-extended/truncated to PC_WIDTH if acc_zero=1 during WB, else pc <= pc+1.
REQ-023 All other opcodes in WB: pc <= pc+1 modulo 2^PC_WIDTH (all-ones wraps to 0); WB -> FETCH.
REQ-024 mux_wr_en SHALL be 0 in every state other than EXEC and never asserted twice per instruction.
REQ-025 mux_sel and alu_op SHALL be 2'b00 outside DECODE and EXEC.
REQ-026 HALT is terminal; exit only by rst; pc frozen.
REQ-027 busy and halted SHALL never be high simultaneously.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, pc=START_PC, instruction register 8'h00, illegal=0, and therefore mux_wr_en=0, mux_sel=0, alu_op=0, busy=0, halted=0, independent of clk.
REQ-029 rst asserted mid-instruction SHALL abort it with no mux_wr_en pulse after rst rises; after release, IDLE awaits start.

Configuration
REQ-030 Macro CTRL_ILLEGAL_TRAP_EN defined: opcodes 4'h4-4'hE in DECODE SHALL go to HALT and set illegal=1 (held until rst).
REQ-031 Macro CTRL_ILLEGAL_TRAP_EN undefined: opcodes 4'h4-4'hE SHALL execute as NOP; illegal tied to 0.

Verification
REQ-032 rst pulse, then start=1 with instr=8'h12: FETCH/DECODE/EXEC/WB in cycles 1-4 after start; mux_sel=2 in DECODE and EXEC; single mux_wr_en pulse in EXEC; pc 0->1 in WB.
REQ-033 instr=8'h21: alu_op=1, mux_sel=3, one mux_wr_en pulse; pc increments.
REQ-034 instr=8'h39 with acc_zero=1 -> pc=9 after WB; with acc_zero=0 -> pc=pc+1; PC_WIDTH=4, pc=4'hF, NOP -> pc=0.
REQ-035 instr=8'hF0: HALT after DECODE, halted=1, busy=0, no mux_wr_en; start ignored; rst returns IDLE, pc=START_PC.
REQ-036 rst asserted during EXEC of LOAD: outputs cleared asynchronously same cycle; no further mux_wr_en.
REQ-037 instr=8'h70: with CTRL_ILLEGAL_TRAP_EN -> HALT, illegal=1; without -> NOP, pc+1, illegal=0.
